// File: rtl/ma_cvxif_mac_copro.sv
// CV-X-IF coprocessor responder: custom-0 add, multiply-accumulate and
// accumulator clear, one instruction in flight, results gated by commit.
module ma_cvxif_mac_copro #(
  parameter int XLEN        = 32,
  parameter int ID_WIDTH    = 3,
  parameter int MAC_LATENCY = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_resp_accept_o,
  output logic                issue_resp_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic                busy_o
);

  localparam int CW = $clog2(MAC_LATENCY + 1);

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_MAC = 3'b001;
  localparam logic [2:0] F3_CLR = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_COMMIT,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]       cnt_q;
  logic                committed_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [4:0]          rd_q;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     rs1_q;
  logic [XLEN-1:0]     rs2_q;
  logic [XLEN-1:0]     acc_q;
  logic [XLEN-1:0]     res_q;

  logic [2:0]      f3;
  logic            recog;
  logic            issue_fire;
  logic            commit_hit;
  logic            kill_hit;
  logic            to_resp;
  logic [CW-1:0]   lat;
  logic [XLEN-1:0] prod;
  logic [XLEN-1:0] res;
  logic            unused_instr;

  assign f3 = issue_instr_i[14:12];
  assign recog = (issue_instr_i[6:0] == 7'b0001011)
              && (issue_instr_i[31:25] == 7'd0)
              && (f3 == F3_ADD || f3 == F3_MAC || f3 == F3_CLR);
  assign unused_instr = ^issue_instr_i[24:15];

  assign issue_resp_accept_o    = recog;
  assign issue_resp_writeback_o = recog;

  // Unrecognized words are acknowledged immediately so the core can trap.
  assign issue_ready_o = !rst_i && (state_q == IDLE)
                      && (!recog || issue_rs_valid_i == 2'b11);

  assign issue_fire = issue_valid_i && issue_ready_o && recog;

  assign commit_hit = commit_valid_i && (commit_id_i == id_q)
                   && !commit_kill_i;
  assign kill_hit   = commit_valid_i && (commit_id_i == id_q)
                   && commit_kill_i;

  assign lat = (f3 == F3_MAC) ? CW'(MAC_LATENCY) : CW'(1);

  assign prod = rs1_q * rs2_q;

  always_comb begin
    res = acc_q;
    unique case (1'b1)
      f3_q == F3_ADD: res = rs1_q + rs2_q;
      f3_q == F3_MAC: res = acc_q + prod;
      default:        res = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue_fire) state_d = EXEC;
      end
      EXEC: begin
        if (kill_hit) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = (committed_q || commit_hit) ? RESP : WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        if (kill_hit)        state_d = IDLE;
        else if (commit_hit) state_d = RESP;
      end
      RESP: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The accumulator only moves once the instruction is known to retire.
  assign to_resp = (state_q != RESP) && (state_d == RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      committed_q <= 1'b0;
      id_q        <= '0;
      rd_q        <= '0;
      f3_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
    end else begin
      state_q <= state_d;
      if (issue_fire) begin
        id_q        <= issue_id_i;
        rd_q        <= issue_instr_i[11:7];
        f3_q        <= f3;
        rs1_q       <= issue_rs1_i;
        rs2_q       <= issue_rs2_i;
        cnt_q       <= lat;
        committed_q <= 1'b0;
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q - CW'(1);
        if (commit_hit) committed_q <= 1'b1;
      end
      if (to_resp) begin
        res_q <= res;
        if (f3_q == F3_MAC) acc_q <= res;
        if (f3_q == F3_CLR) acc_q <= '0;
      end
    end
  end

  assign result_valid_o = (state_q == RESP);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = id_q;
  assign result_rd_o    = rd_q;
  assign result_data_o  = res_q;
  assign busy_o         = (state_q != IDLE);

endmodule
